// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths and FSM state type for the data-memory line controller
package dmem_pkg;
    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;
endpackage

// File: rtl/dmem_line_ctrl_if.sv
// rtl/dmem_line_ctrl_if.sv - request/response bundle between the data cache and the line controller
interface dmem_line_ctrl_if;
    import dmem_pkg::*;

    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              err_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, err_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, err_o
    );
endinterface

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - MEM_LINES x LINE_W storage, synchronous write, combinational read, never reset
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int  MEM_LINES = 512,
    localparam int IDX_W     = $clog2(MEM_LINES)
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [MEM_LINES];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_line_ctrl.sv
// rtl/dmem_line_ctrl.sv - fixed-latency single-outstanding line read/write controller
// Optional out-of-range detection on upper address bits: DMEM_RANGE_CHECK_EN
module dmem_line_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_LINES = 512,
    parameter int LATENCY   = 10
) (
    input logic          clk_i,
    input logic          rst_i,
    dmem_line_ctrl_if.slave bus
);
    localparam int               IDX_W    = $clog2(MEM_LINES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              accept;
    logic              lat_write;
    logic              lat_oor;
    logic [IDX_W-1:0]  lat_idx;
    logic [LINE_W-1:0] lat_data;
    logic [LINE_W-1:0] rdata;
    logic              oor_in;
    logic              in_ack;
    logic              we;
    logic              unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_in      = |bus.addr_i[ADDR_W-1:OFFSET_W+IDX_W];
    assign unused_addr = ^bus.addr_i[OFFSET_W-1:0];
`else
    assign oor_in      = 1'b0;
    assign unused_addr = ^{bus.addr_i[ADDR_W-1:OFFSET_W+IDX_W], bus.addr_i[OFFSET_W-1:0]};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_oor   <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_write <= bus.write_i;
                lat_oor   <= oor_in;
                lat_idx   <= bus.addr_i[OFFSET_W +: IDX_W];
                lat_data  <= bus.data_i;
            end
        end
    end

    // Request inputs are only looked at in IDLE, so the in-flight transaction is frozen.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable_i) begin
                    accept  = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                cnt_n = cnt - 1'b1;
                if (cnt == 8'd1) begin
                    state_n = ACK;
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ack = (state == ACK);
    // Write commits on the edge leaving ACK; an async reset in ACK drops in_ack first.
    assign we     = in_ack && lat_write && !lat_oor;

    dmem_line_array #(
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk_i (clk_i),
        .we    (we),
        .waddr (lat_idx),
        .wdata (lat_data),
        .raddr (lat_idx),
        .rdata (rdata)
    );

    assign bus.ack_o  = in_ack;
    assign bus.data_o = (in_ack && !lat_write && !lat_oor) ? rdata : '0;
`ifdef DMEM_RANGE_CHECK_EN
    assign bus.err_o  = in_ack && lat_oor;
`else
    assign bus.err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_line_ctrl.sv
// tb/tb_dmem_line_ctrl.sv - directed self-checking bench for dmem_line_ctrl (LATENCY 10 and 2 instances)
module tb_dmem_line_ctrl;
    import dmem_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    dmem_line_ctrl_if bus ();
    dmem_line_ctrl_if bus2 ();

    dmem_line_ctrl #(.MEM_LINES(512), .LATENCY(10)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    dmem_line_ctrl #(.MEM_LINES(512), .LATENCY(2)) dut2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus2.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [255:0] P_A5 = {32{8'hA5}};
    localparam logic [255:0] P2   = {8{32'h1234_5678}};
    localparam logic [255:0] P3   = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] P4   = {8{32'h0F0F_3C3C}};
    localparam logic [255:0] P5   = {8{32'hCAFE_0080}};
    localparam logic [255:0] P6   = {8{32'h6666_6666}};
    localparam logic [255:0] P7   = {8{32'h7777_4000}};
    localparam logic [255:0] P8   = {8{32'h8888_0000}};
    localparam logic [255:0] P9   = {8{32'h9999_0020}};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge after the ack cycle. lat counts edges from accept to ack.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                       input bit disturb, output int lat, output logic [255:0] rdata, output logic err);
        bus.enable_i = 1'b1;
        bus.write_i  = wr;
        bus.addr_i   = addr;
        bus.data_i   = wdata;
        @(posedge clk_i);
        lat = 1;
        @(negedge clk_i);
        bus.enable_i = 1'b0;
        if (disturb) begin
            bus.addr_i  = ~addr;
            bus.data_i  = ~wdata;
            bus.write_i = ~wr;
        end
        check("busy_data_zero", bus.data_o, '0);
        while (!bus.ack_o && lat < 50) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        rdata = bus.data_o;
        err   = bus.err_o;
        @(negedge clk_i);
        check("ack_one_cycle", bus.ack_o, 1'b0);
    endtask

    task automatic txn2(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                        output int lat, output logic [255:0] rdata);
        bus2.enable_i = 1'b1;
        bus2.write_i  = wr;
        bus2.addr_i   = addr;
        bus2.data_i   = wdata;
        @(posedge clk_i);
        lat = 1;
        @(negedge clk_i);
        bus2.enable_i = 1'b0;
        while (!bus2.ack_o && lat < 50) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        rdata = bus2.data_o;
        @(negedge clk_i);
        check("l2_ack_one_cycle", bus2.ack_o, 1'b0);
    endtask

    initial begin
        int            lat;
        int            n;
        int            acks;
        logic [255:0]  rd;
        logic          er;

        rst_i = 1'b1;
        bus.enable_i  = 1'b0; bus.write_i  = 1'b0; bus.addr_i  = '0; bus.data_i  = '0;
        bus2.enable_i = 1'b0; bus2.write_i = 1'b0; bus2.addr_i = '0; bus2.data_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ack", bus.ack_o, 1'b0);
        check("rst_data", bus.data_o, '0);
        check("rst_err", bus.err_o, 1'b0);
        check("rst_ack_l2", bus2.ack_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Write then read back the A5 pattern at line 2.
        txn(1'b1, 32'h0000_0040, P_A5, 1'b0, lat, rd, er);
        check("wr40_lat", lat, 10);
        check("wr40_data_zero", rd, '0);
        check("wr40_err", er, 1'b0);
        txn(1'b0, 32'h0000_0040, '0, 1'b0, lat, rd, er);
        check("rd40_lat", lat, 10);
        check("rd40_data", rd, P_A5);

        // Inputs disturbed and enable dropped during BUSY.
        txn(1'b1, 32'h0000_0060, P2, 1'b0, lat, rd, er);
        txn(1'b0, 32'h0000_0060, '0, 1'b1, lat, rd, er);
        check("disturb_lat", lat, 10);
        check("disturb_data", rd, P2);

        // Writeback then refill with enable held through ACK.
        txn(1'b1, 32'h0000_0200, P4, 1'b0, lat, rd, er);
        bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_0100; bus.data_i = P3;
        @(posedge clk_i);
        n = 1;
        @(negedge clk_i);
        while (!bus.ack_o && n < 50) begin
            @(posedge clk_i); n++; @(negedge clk_i);
        end
        check("b2b_first_lat", n, 10);
        bus.write_i = 1'b0;
        bus.addr_i  = 32'h0000_0200;
        n = 0;
        @(posedge clk_i); n++; @(negedge clk_i);
        check("b2b_idle_no_ack", bus.ack_o, 1'b0);
        @(posedge clk_i); n++; @(negedge clk_i);
        bus.enable_i = 1'b0;
        while (!bus.ack_o && n < 50) begin
            @(posedge clk_i); n++; @(negedge clk_i);
        end
        check("b2b_second_gap", n, 11);
        check("b2b_refill_data", bus.data_o, P4);
        @(negedge clk_i);
        txn(1'b0, 32'h0000_0100, '0, 1'b0, lat, rd, er);
        check("b2b_writeback_landed", rd, P3);

        // Reset mid-write must leave the old line contents.
        txn(1'b1, 32'h0000_0080, P5, 1'b0, lat, rd, er);
        bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_0080; bus.data_i = P6;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.enable_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_ack", bus.ack_o, 1'b0);
        rst_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (bus.ack_o) acks++;
        end
        check("rst_no_ack", acks, 0);
        txn(1'b0, 32'h0000_0080, '0, 1'b0, lat, rd, er);
        check("rst_old_contents", rd, P5);

        // Upper address bits: error with range check, wrap to line 0 without.
        txn(1'b1, 32'h0000_0000, P8, 1'b0, lat, rd, er);
        txn(1'b1, 32'h0000_4000, P7, 1'b0, lat, rd, er);
        txn(1'b0, 32'h0000_0000, '0, 1'b0, lat, rd, er);
`ifdef DMEM_RANGE_CHECK_EN
        check("oor_line0", rd, P8);
        txn(1'b1, 32'h0000_4000, P7, 1'b0, lat, rd, er);
        check("oor_err", er, 1'b1);
`else
        check("wrap_line0", rd, P7);
        txn(1'b1, 32'h0000_4000, P7, 1'b0, lat, rd, er);
        check("wrap_err", er, 1'b0);
`endif

        // Minimum latency instance.
        txn2(1'b1, 32'h0000_0020, P9, lat, rd);
        check("l2_wr_lat", lat, 2);
        txn2(1'b0, 32'h0000_0020, '0, lat, rd);
        check("l2_rd_lat", lat, 2);
        check("l2_rd_data", rd, P9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/dmem_line_ctrl.md
DMEM_LINE_CTRL -- requirements
Module: dmem_line_ctrl

Interface
REQ-001 SHALL have parameter MEM_LINES, default 512: number of 256-bit lines stored.
REQ-002 SHALL have parameter LATENCY, default 10: clock cycles from request accept to ack_o; legal range 2..255.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port enable_i, input, 1: request valid from the data cache.
REQ-006 SHALL have port write_i, input, 1: 1 = line write, 0 = line read; qualified by enable_i.
REQ-007 SHALL have port addr_i, input, 32: byte address; bits [4:0] ignored, line index = addr_i[5 +: log2(MEM_LINES)].
REQ-008 SHALL have port data_i, input, 256: write line data.
REQ-009 SHALL have port ack_o, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256: read line data, valid only while ack_o=1 for a read.
REQ-011 SHALL have port err_o, output, 1: out-of-range flag, valid only while ack_o=1.

Function
REQ-012 SHALL implement states IDLE, BUSY, ACK.
REQ-013 IDLE: if enable_i=1 SHALL latch addr_i, data_i, write_i, load counter with LATENCY-1 and go to BUSY; else stay IDLE.
REQ-014 BUSY: SHALL decrement the counter each cycle; at counter=1 SHALL go to ACK.
REQ-015 ACK: SHALL assert ack_o for exactly one cycle and return to IDLE unconditionally; enable_i SHALL be ignored in ACK.
REQ-016 Latency: request sampled in IDLE at edge N SHALL produce ack_o=1 in the cycle following edge N+LATENCY-1.
REQ-017 Write SHALL be committed to the array at the edge leaving ACK, using latched address/data.
REQ-018 Read SHALL drive data_o from the array at the latched index during ACK; data_o SHALL be 0 outside ACK or on writes.
REQ-019 Changes on addr_i, data_i, write_i, or deassertion of enable_i during BUSY/ACK SHALL NOT affect the transaction in flight.
REQ-020 A request held high through ACK SHALL be accepted as a new transaction in the first IDLE cycle (back-to-back writeback then refill).
REQ-021 Only one transaction SHALL be outstanding; no queuing.

Reset
REQ-022 On rst_i=1: state IDLE, counter 0, ack_o 0, data_o 0, err_o 0, latched request cleared.
REQ-023 Reset asserted in BUSY or ACK SHALL discard the transaction; no array write SHALL occur.
REQ-024 The storage array SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro DMEM_RANGE_CHECK_EN defined: latched address with any bit above the index field nonzero SHALL be out of range; write suppressed, data_o = 0, err_o = 1 during ACK.
REQ-026 Macro DMEM_RANGE_CHECK_EN undefined: upper address bits ignored (index wraps modulo MEM_LINES), err_o tied 0.

Structure
REQ-027 Package dmem_pkg SHALL hold LINE_W=256, ADDR_W=32, OFFSET_W=5 and the state typedef.
REQ-028 Storage SHALL be one sub-module dmem_line_array (synchronous write port, combinational read port, MEM_LINES x LINE_W).

Verification
REQ-029 Write line 0x...A5 pattern to addr 0x0000_0040, then read same -> ack_o high exactly 10 cycles after each accept, read data_o equals pattern.
REQ-030 Read accepted, addr_i/data_i toggled and enable_i dropped during BUSY -> ack after 10 cycles with data of original address.
REQ-031 Write to 0x0000_0100 with enable_i held through ACK, write_i then cleared (refill read of 0x0000_0200) -> second accept in cycle after ACK, second ack 10 cycles later.
REQ-032 rst_i asserted at cycle 5 of a write to 0x0000_0080 -> ack_o never asserts, later read of 0x0000_0080 returns prior contents.
REQ-033 With DMEM_RANGE_CHECK_EN, write to 0x0000_4000 -> err_o=1 with ack, line 0 unchanged; without macro same write lands in line 0, err_o=0.
REQ-034 LATENCY=2 override: read accept -> ack_o in the cycle after the next edge, no cycle skipped or duplicated.
